// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, one bit per cycle.
module mdu_iterative #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
   localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
   localparam logic [OPW-1:0] OP_DIV   = OPW'(2);
   localparam logic [OPW-1:0] OP_DIVU  = OPW'(3);
   localparam logic [OPW-1:0] OP_MTHI  = OPW'(4);
   localparam logic [OPW-1:0] OP_MTLO  = OPW'(5);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH:0]     acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   operand;
   logic [CW-1:0]      cnt;

   logic               op_iter;
   logic               op_div;
   logic               op_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fin;
   logic [WIDTH-1:0]   quot_fin;
   logic [WIDTH-1:0]   rem_fin;
   logic [CW-1:0]      cnt_nxt;

   always_comb begin
      op_iter   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
      op_div    = (op == OP_DIV) || (op == OP_DIVU);
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = op_signed & a[WIDTH-1];
      b_neg     = op_signed & b[WIDTH-1];
      a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
      b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
   end

   // acc_hi/acc_lo hold {partial product, remaining multiplier} for multiply and
   // {partial remainder, dividend/quotient shift register} for divide.
   always_comb begin
      mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? operand : '0)};
      div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, operand};
      step_hi   = '0;
      step_lo   = '0;
      if (is_div) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift;
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = {1'b0, mul_sum[WIDTH:1]};
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod     = {step_hi[WIDTH-1:0], step_lo};
      prod_fin = neg_res ? (~prod + (2*WIDTH)'(1)) : prod;
      if (div_zero)
         quot_fin = '1;
      else
         quot_fin = neg_res ? (~step_lo + WIDTH'(1)) : step_lo;
      rem_fin  = neg_rem ? (~step_hi[WIDTH-1:0] + WIDTH'(1)) : step_hi[WIDTH-1:0];
      cnt_nxt  = cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         operand  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (op_iter) begin
                     state   <= S_RUN;
                     busy    <= 1'b1;
                     cnt     <= '0;
                     is_div  <= op_div;
                     acc_hi  <= '0;
                     neg_res <= a_neg ^ b_neg;
                     if (op_div) begin
                        acc_lo   <= a_mag;
                        operand  <= b_mag;
                        neg_rem  <= a_neg;
                        div_zero <= (b == '0);
                     end else begin
                        acc_lo   <= b_mag;
                        operand  <= a_mag;
                        neg_rem  <= 1'b0;
                        div_zero <= 1'b0;
                     end
                  end else if (op == OP_MTHI) begin
                     hi <= a;
                  end else if (op == OP_MTLO) begin
                     lo <= a;
                  end
               end
            end
            S_RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt_nxt;
               if (cnt_nxt == CW'(WIDTH)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (is_div) begin
                     hi <= rem_fin;
                     lo <= quot_fin;
                  end else begin
                     hi <= prod_fin[2*WIDTH-1:WIDTH];
                     lo <= prod_fin[WIDTH-1:0];
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at WIDTH=32.
module tb_mdu_iterative;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mdu_iterative #(.WIDTH(32), .OPW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one iterative op and follow it to completion; inputs change on negedges.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 64'(n), 64'd32);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic move_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = 32'h0;
      @(negedge clk);
      start = 1'b0;
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      #12;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      move_op("mtlo", 3'd5, 32'h1234_5678, 32'hFFFF_FFFE, 32'h1234_5678);
      move_op("mthi", 3'd4, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678);
      move_op("noop6", 3'd6, 32'h5555_5555, 32'hCAFE_F00D, 32'h1234_5678);
      run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_7_2", 3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
      run_op("divu_by0", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
      run_op("div_by0", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("div_7_neg2", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("mult_min_x2", 3'd0, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("multu_x0", 3'd1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

      // Starts during a running MULT must be dropped; hi/lo hold until completion.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'h0000_0007; b = 32'hFFFF_FFFA;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      repeat (4) begin @(negedge clk); n++; end
      start = 1'b1; op = 3'd2; a = 32'h0000_0064; b = 32'h0000_0003;
      @(negedge clk); n++;
      start = 1'b0;
      repeat (3) begin @(negedge clk); n++; end
      start = 1'b1; op = 3'd4; a = 32'hBADB_AD00;
      @(negedge clk); n++;
      start = 1'b0;
      check("ignore hi_hold", 64'(hi), 64'd0);
      check("ignore lo_hold", 64'(lo), 64'd0);
      while (busy && n < 100) begin
         @(negedge clk);
         if (busy) n++;
      end
      check("ignore busy_cycles", 64'(n), 64'd32);
      check("ignore done", 64'(done), 64'd1);
      check("ignore hi", 64'(hi), 64'hFFFF_FFFF);
      check("ignore lo", 64'(lo), 64'hFFFF_FFD6);

      // Asynchronous reset in the middle of a DIV.
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'h0000_0064; b = 32'h0000_0007;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort busy_before", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort hi", 64'(hi), 64'd0);
      check("abort lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("multu_2x3", 3'd1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
